// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux; grant tenure bounded by HOLD_MAX.
// Optional MUX8_ARB_PRIO0_EN: requester 0 gets absolute, pre-empting priority.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic       y
);

    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned CNTW = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [IDXW-1:0]   last;
    logic [CNTW-1:0]   hold_cnt;

    logic              rel;
    logic              preempt;
    logic [IDXW-1:0]   rel_ptr;
    logic [IDXW:0]     cand;

    // Returns {found, index}; scans ptr+1 .. ptr+8 so ptr itself has lowest priority.
    function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] r, input logic [IDXW-1:0] ptr);
        logic [IDXW:0]   res;
        logic [IDXW-1:0] idx;
        res = '0;
        for (int i = int'(N); i >= 1; i--) begin
            idx = ptr + IDXW'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] ptr);
`ifdef MUX8_ARB_PRIO0_EN
        if (r[0]) return {1'b1, IDXW'(0)};
`endif
        return rr_pick(r, ptr);
    endfunction

    // Release/pre-emption decision and the next winner for the current edge.
    always_comb begin
        rel     = !req[sel] || (hold_cnt == CNTW'(HOLD_MAX));
        preempt = 1'b0;
        rel_ptr = sel;
`ifdef MUX8_ARB_PRIO0_EN
        preempt = req[0] && (sel != IDXW'(0));
        // A priority tenure of requester 0 does not disturb the rotation pointer.
        if (sel == IDXW'(0)) rel_ptr = last;
`endif
        cand = pick(req, (state == IDLE) ? last : rel_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= IDXW'(N - 1);
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand[IDXW]) begin
                        gnt      <= N'(1) << cand[IDXW-1:0];
                        sel      <= cand[IDXW-1:0];
                        valid    <= 1'b1;
                        hold_cnt <= CNTW'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel || preempt) begin
                        last <= rel_ptr;
                        if (cand[IDXW]) begin
                            gnt      <= N'(1) << cand[IDXW-1:0];
                            sel      <= cand[IDXW-1:0];
                            hold_cnt <= CNTW'(1);
                        end else begin
                            gnt      <= '0;
                            valid    <= 1'b0;
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign y = valid ? din[sel] : 1'b0;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 bit mux among eight requesters.
- Generates the 3-bit select and a one-hot grant, and delivers the selected data bit.
- Sits in front of the 8:1 mux datapath. Requester i owns mux input din[i] while granted.
- Grant tenure is bounded by a programmable hold limit so that no requester starves.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one requester may hold the grant. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  8  request vector; req[i] high means requester i wants the mux
- din  input  8  mux data inputs; din[i] belongs to requester i
- gnt  output 8  one-hot grant, registered; all zero when idle
- sel  output 3  registered mux select; index of the current grant
- valid  output 1  registered; high while a grant is active
- y  output 1  combinational; y = din[sel] when valid=1, else 0

Behaviour:
- Clock and reset (already decided):
  - Single clock, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - gnt=8'h00, sel=3'd0, valid=0, y=0.
  - Internal last-served pointer=3'd7, so requester 0 wins the first arbitration.
  - hold_cnt=0, state=IDLE.
- States: IDLE and GRANT.
- Round-robin search:
  - Order is last+1, last+2, …, last+8, all mod 8.
  - The first index with req high wins.
  - The search includes last itself, at lowest priority.
- IDLE:
  - If req==0: stay in IDLE; outputs stay at their reset values.
  - Otherwise, on the next edge: gnt=one-hot(winner), sel=winner, valid=1, hold_cnt=1, go to GRANT.
  - Latency: req asserted in cycle N gives gnt/valid in cycle N+1.
- GRANT, evaluated every edge:
  - Release occurs if req[sel]==0 or hold_cnt==HOLD_MAX.
  - On release: last=sel, then run a new search using the updated pointer.
    - If a winner exists: grant it on the same edge (back-to-back, no idle cycle) and set hold_cnt=1.
    - If no winner: gnt=0, valid=0, go to IDLE; sel keeps its last value.
  - No release: hold_cnt increments; gnt and sel are unchanged.
- Single requester: if only requester k is requesting, it is re-granted after each hold expiry. gnt stays high continuously and hold_cnt restarts at 1.
- HOLD_MAX=1: re-arbitration happens every cycle, giving strict per-cycle rotation among active requesters.
- Counter widths:
  - hold_cnt is 8 bits and never exceeds HOLD_MAX.
  - Pointer arithmetic is modulo 8 (3-bit wrap: 7+1 gives 0).
- Request and reset timing:
  - A requester dropping req in the same cycle as hold expiry is a single release, not double-counted.
  - Requests are never latched; a pulse that is not sampled while arbitration is open is lost.
  - rst asserted mid-grant: all outputs return to reset values on that edge, regardless of state or req.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[sel]==valid.

Optional Feature:
- Macro: MUX8_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has absolute priority. Whenever req[0] is high, the next arbitration picks 0 regardless of the pointer.
  - While another requester holds the grant and req[0] rises, the current holder is pre-empted on the next edge: gnt moves to 0, hold_cnt=1, last=preempted index.
  - Requester 0's own tenure is still bounded by HOLD_MAX. If req[0] stays high at expiry it is re-granted.
- Not defined: pure round-robin as above, with no pre-emption.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, valid=0, sel=0, y=0 throughout.
- Reset; req=8'hFF held; HOLD_MAX=4 -> grants 0,1,2,…,7,0 in turn, each held exactly 4 cycles, no gaps. With din=8'hA5, y follows din[sel] (1,0,1,0,0,1,0,1).
- req=8'h24 (requesters 2 and 5), requester 2 drops req after 2 cycles of grant -> gnt switches to 8'h20 on the next edge. Requester 5 then holds for 4 cycles, then the grant returns to 2 if req[2] is high again.
- Only req[7]=1 with HOLD_MAX=1 -> gnt=8'h80 continuously, sel=7, valid=1. Then req[0] also rises -> grant alternates 0,7,0,… each cycle (pointer wraps 7 to 0).
- rst pulsed for one cycle while gnt=8'h08, hold_cnt=2 -> next cycle gnt=0, valid=0, sel=0. With req=8'h08 still high, the next grant after reset is requester 3 (pointer reset to 7, so the search starts at 0).
- With MUX8_ARB_PRIO0_EN: requester 4 granted; req[0] rises in cycle N -> gnt=8'h01 in cycle N+1. After requester 0 drops, the search resumes from 5. Without the macro: requester 4 completes its tenure first.
